// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac -- fractional-N baud tick generator for the UART TX/RX paths.
//
// A phase accumulator adds inc_reg every enabled cycle. Each carry out of the
// accumulator becomes one oversample tick. The average tick rate is
// CLK_FREQ*inc_reg/2^ACC_W, and tick spacing jitters by at most one clock.
// A phase counter groups OVERSAMPLE oversample ticks into one bit tick.
// SYNC moves the bit phase to mid-bit, which the RX side uses to capture the start bit.
//
// Optional feature (macro UART_BAUD_RUNTIME_EN):
//   defined   - BAUD_INC / INC_LOAD ports exist and inc_reg can be reloaded at run time
//   undefined - inc_reg is the constant INC_DEFAULT
//
// Ports:
//   CLK          system clock
//   RST          asynchronous reset, active-high
//   EN           run enable; accumulator and phase counter hold while low
//   SYNC         single-cycle phase realign strobe (acts regardless of EN)
//   BAUD_INC     runtime increment value          (UART_BAUD_RUNTIME_EN only)
//   INC_LOAD     load strobe for BAUD_INC          (UART_BAUD_RUNTIME_EN only)
//   BAUD_OS_EN   oversample tick, one-cycle pulse
//   BAUD_BIT_EN  bit tick, one-cycle pulse, always coincident with BAUD_OS_EN
//   BIT_PHASE    current oversample index within the bit (registered)

module uart_baud_gen_frac #(
    parameter int                CLK_FREQ    = 125000000,
    parameter int                BAUD_RATE   = 115200,
    parameter int                OVERSAMPLE  = 16,
    parameter int                ACC_W       = 24,
    parameter longint unsigned   INC_DEFAULT =
        (((longint'(BAUD_RATE) * longint'(OVERSAMPLE)) << ACC_W) + longint'(CLK_FREQ / 2))
        / longint'(CLK_FREQ),
    localparam int               PH_W        = $clog2(OVERSAMPLE)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             SYNC,
`ifdef UART_BAUD_RUNTIME_EN
    input  logic [ACC_W-1:0] BAUD_INC,
    input  logic             INC_LOAD,
`endif
    output logic             BAUD_OS_EN,
    output logic             BAUD_BIT_EN,
    output logic [PH_W-1:0]  BIT_PHASE
);

    // Catch bad configurations at elaboration rather than in silicon.
    if (INC_DEFAULT >= (64'd1 << ACC_W)) begin : g_inc_chk
        $error("uart_baud_gen_frac: INC_DEFAULT does not fit in ACC_W bits");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE > 32) || ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0)) begin : g_os_chk
        $error("uart_baud_gen_frac: OVERSAMPLE must be a power of two in 4..32");
    end

    localparam logic [ACC_W-1:0] INC_RST  = INC_DEFAULT[ACC_W-1:0];
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OVERSAMPLE / 2);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_reg;
    logic [PH_W-1:0]  os_cnt;
    logic [ACC_W:0]   sum;
    logic             carry;

`ifdef UART_BAUD_RUNTIME_EN
    // A load is independent of SYNC/EN. The add in the load cycle still
    // sees the old value because sum is formed from the current inc_reg.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            inc_reg <= INC_RST;
        else if (INC_LOAD)
            inc_reg <= BAUD_INC;
    end
`else
    assign inc_reg = INC_RST;
`endif

    assign sum   = {1'b0, acc} + {1'b0, inc_reg};
    assign carry = sum[ACC_W];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc         <= '0;
            os_cnt      <= '0;
            BAUD_OS_EN  <= 1'b0;
            BAUD_BIT_EN <= 1'b0;
        end else if (SYNC) begin
            // Restart the accumulator and put the phase at mid-bit. A carry
            // in this same cycle is dropped.
            acc         <= '0;
            os_cnt      <= PH_MID;
            BAUD_OS_EN  <= 1'b0;
            BAUD_BIT_EN <= 1'b0;
        end else if (EN) begin
            acc         <= sum[ACC_W-1:0];
            BAUD_OS_EN  <= carry;
            BAUD_BIT_EN <= carry && (os_cnt == PH_LAST);
            if (carry)
                os_cnt <= os_cnt + 1'b1;  // power-of-two width wraps naturally
        end else begin
            BAUD_OS_EN  <= 1'b0;
            BAUD_BIT_EN <= 1'b0;
        end
    end

    assign BIT_PHASE = os_cnt;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Self-checking bench for uart_baud_gen_frac (CLK_FREQ=1000, BAUD_RATE=10,
// OVERSAMPLE=16, ACC_W=16 -> INC_DEFAULT=10486). A reference model pushes the
// expected outputs for each edge into a queue. A monitor on the falling edge
// pops each entry and compares it. Scenario-level checks (tick counts, gaps,
// SYNC/EN/reset behaviour) sit on top of that. Runtime-load scenarios are
// built only with UART_BAUD_RUNTIME_EN.

module tb_uart_baud_gen_frac;

    localparam int INC_DEF = 10486;
`ifdef UART_BAUD_RUNTIME_EN
    localparam bit RT = 1'b1;
`else
    localparam bit RT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sync = 1'b0;
    logic        inc_load = 1'b0;
    logic [15:0] baud_inc = '0;
    logic        os_en;
    logic        bit_en;
    logic [3:0]  bit_phase;

    uart_baud_gen_frac #(
        .CLK_FREQ   (1000),
        .BAUD_RATE  (10),
        .OVERSAMPLE (16),
        .ACC_W      (16)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .EN          (en),
        .SYNC        (sync),
`ifdef UART_BAUD_RUNTIME_EN
        .BAUD_INC    (baud_inc),
        .INC_LOAD    (inc_load),
`endif
        .BAUD_OS_EN  (os_en),
        .BAUD_BIT_EN (bit_en),
        .BIT_PHASE   (bit_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       os;
        logic       bt;
        logic [3:0] ph;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_acc  = 0;
    int   m_cnt  = 0;
    int   m_inc  = INC_DEF;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, push the model's
    // prediction, and return just after the rising edge.
    task automatic step(input logic e, input logic s, input logic l, input logic [15:0] v);
        exp_t x;
        int   sum;
        @(negedge clk);
        #1;
        en = e; sync = s; inc_load = l; baud_inc = v;
        if (s) begin
            m_acc = 0; m_cnt = 8; x.os = 1'b0; x.bt = 1'b0;
        end else if (e) begin
            sum   = m_acc + m_inc;
            x.os  = (sum >= 65536);
            x.bt  = x.os && (m_cnt == 15);
            m_acc = sum % 65536;
            if (x.os) m_cnt = (m_cnt + 1) % 16;
        end else begin
            x.os = 1'b0; x.bt = 1'b0;
        end
        x.ph = 4'(m_cnt);
        if (RT && inc_load) m_inc = int'(baud_inc);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mx = sb.pop_front();
            chk("sb_os", int'(os_en), int'(mx.os));
            chk("sb_bit", int'(bit_en), int'(mx.bt));
            chk("sb_phase", int'(bit_phase), int'(mx.ph));
        end
    end

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; sync = 1'b0; inc_load = 1'b0;
        sb.delete();
        m_acc = 0; m_cnt = 0; m_inc = INC_DEF;
        repeat (2) @(negedge clk);
        chk("rst_os", int'(os_en), 0);
        chk("rst_bit", int'(bit_en), 0);
        chk("rst_phase", int'(bit_phase), 0);
        #1;
        rst = 1'b0;
    endtask

    // Free-run n cycles and count ticks. bad counts OS gaps outside [glo,ghi]
    // and bit ticks with the wrong gap. It also counts bit ticks not on an
    // OS tick and bit ticks not at the 15->0 phase wrap.
    task automatic run(input int n, input int glo, input int ghi, input int bgap,
                       output int os_n, output int bit_n, output int bad);
        int lo = -1;
        int lb = -1;
        logic [3:0] pp;
        os_n = 0; bit_n = 0; bad = 0;
        pp = bit_phase;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'd0);
            if (os_en) begin
                os_n++;
                if (lo >= 0 && ((i - lo) < glo || (i - lo) > ghi)) bad++;
                lo = i;
            end
            if (bit_en) begin
                bit_n++;
                if (!os_en || pp != 4'd15 || bit_phase != 4'd0) bad++;
                if (bgap > 0 && lb >= 0 && (i - lb) != bgap) bad++;
                lb = i;
            end
            pp = bit_phase;
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step(1'b1, 1'b0, 1'b0, 16'd0);
            n++;
        end while (!os_en && n < 100);
    endtask

    task automatic to_bit(output int ticks, output int clks);
        ticks = 0; clks = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'd0);
            clks++;
            if (os_en) ticks++;
            if (bit_en) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int os_n, bit_n, bad, t, c, k, j, frz, gap_ticks;
        logic [3:0] ph0;

        // Reset state, then scenario 1: long free run at the default increment.
        do_reset();
        run(10000, 6, 7, 0, os_n, bit_n, bad);
        chk("s1_os_count", os_n, 1600);
        chk("s1_bit_count", bit_n, 100);
        chk("s1_gap_phase", bad, 0);

`ifdef UART_BAUD_RUNTIME_EN
        // Scenario 2: load 16384 one cycle after reset release.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b0, 1'b1, 16'd16384);
        run(400, 4, 4, 64, os_n, bit_n, bad);
        chk("s2_os_count", os_n, 100);
        chk("s2_gap_phase", bad, 0);
`endif

        // Scenario 3: SYNC. With the 4-clock period, it lands on a carry edge.
        wait_tick(t);
        repeat (RT ? 3 : 2) step(1'b1, 1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b1, 1'b0, 16'd0);
        chk("s3_os_after_sync", int'(os_en), 0);
        chk("s3_bit_after_sync", int'(bit_en), 0);
        chk("s3_phase_after_sync", int'(bit_phase), 8);
        to_bit(t, c);
        chk("s3_ticks_to_bit", t, 8);
`ifdef UART_BAUD_RUNTIME_EN
        chk("s3_clks_to_bit", c, 32);
`else
        chk("s3_clks_to_bit_range", int'(c >= 48 && c <= 56), 1);
`endif

        // Scenario 4: drop EN for 20 clocks, two clocks after a tick.
        wait_tick(t);
        step(1'b1, 1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b0, 1'b0, 16'd0);
        k = 2;
        ph0 = bit_phase;
        gap_ticks = 0; frz = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'd0);
            if (os_en || bit_en) gap_ticks++;
            if (bit_phase != ph0) frz++;
        end
        chk("s4_no_ticks", gap_ticks, 0);
        chk("s4_phase_frozen", frz, 0);
        wait_tick(j);
`ifdef UART_BAUD_RUNTIME_EN
        chk("s4_resume_phase", k + j, 4);
`else
        chk("s4_resume_phase", int'((k + j) >= 6 && (k + j) <= 7), 1);
`endif

        // Scenario 5: async reset during an OS pulse, between clock edges.
        wait_tick(t);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("s5_async_os", int'(os_en), 0);
        chk("s5_async_bit", int'(bit_en), 0);
        chk("s5_async_phase", int'(bit_phase), 0);
        do_reset();
        run(700, 6, 7, 0, os_n, bit_n, bad);
        chk("s5_os_count", os_n, 112);
        chk("s5_gap_phase", bad, 0);

`ifdef UART_BAUD_RUNTIME_EN
        // Scenario 6: zero increment, then 32768, then a load coincident with SYNC.
        step(1'b1, 1'b0, 1'b1, 16'd0);
        step(1'b1, 1'b0, 1'b0, 16'd0);
        gap_ticks = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'd0);
            if (os_en || bit_en) gap_ticks++;
        end
        chk("s6_zero_inc_ticks", gap_ticks, 0);
        step(1'b1, 1'b0, 1'b1, 16'd32768);
        step(1'b1, 1'b0, 1'b0, 16'd0);
        run(200, 2, 2, 32, os_n, bit_n, bad);
        chk("s6_os_count", os_n, 100);
        chk("s6_gap_phase", bad, 0);
        step(1'b1, 1'b1, 1'b1, 16'd16384);
        chk("s6_sync_load_os", int'(os_en), 0);
        chk("s6_sync_load_phase", int'(bit_phase), 8);
        to_bit(t, c);
        chk("s6_ticks_to_bit", t, 8);
        chk("s6_clks_to_bit", c, 32);
`endif

        @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
